// File: rtl/fpmul_capture.sv
// fpmul_capture: records fpmul operands/results, aligns them across the
// multiplier latency, buffers them in a FIFO and streams each record out as
// four 32-bit words (a, b, r, {31'b0, omu}) over valid/ready.

package fpmul_capture_pkg;

   // One captured multiplier transaction.
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        omu;
   } rec_t;

endpackage

module fpmul_capture
   import fpmul_capture_pkg::*;
#(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned ADDR_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              enable,
   input  logic [31:0]       a,
   input  logic [31:0]       b,
   input  logic [31:0]       r,
   input  logic              omu,
   output logic [31:0]       out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic              overflow,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned DL_W   = LATENCY * 32;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Alignment delay line: bit/slot 0 is the newest entry.
   logic [LATENCY-1:0]       dl_v;
   logic [LATENCY-1:0][31:0] dl_a;
   logic [LATENCY-1:0][31:0] dl_b;

   rec_t                     mem [DEPTH];

   logic [ADDR_W-1:0]        wr_ptr;
   logic [ADDR_W-1:0]        rd_ptr;
   logic [ADDR_W-1:0]        wr_ptr_nxt;
   logic [ADDR_W-1:0]        rd_ptr_nxt;
   logic [CNT_W-1:0]         count_nxt;
   logic                     overflow_nxt;

   state_t                   state;
   state_t                   state_nxt;
   logic [1:0]               w;
   logic [1:0]               w_nxt;

   logic                     hs_c;
   logic                     pop_c;
   logic                     push_c;
   logic                     push_ok_c;
   rec_t                     new_rec_c;
   rec_t                     head_c;

   logic [31:0]              out_data_nxt;
   logic                     out_valid_nxt;
   logic                     out_last_nxt;

   // Select one 32-bit word of a record in streaming order.
   function automatic logic [31:0] word_sel(input rec_t rec, input logic [1:0] idx);
      logic [31:0] res;
      case (idx)
         2'd0:    res = rec.a;
         2'd1:    res = rec.b;
         2'd2:    res = rec.r;
         default: res = {31'b0, rec.omu};
      endcase
      return res;
   endfunction

   // Delay-line valid bits; clear and reset drop all in-flight operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_v <= '0;
      end else if (clear) begin
         dl_v <= '0;
      end else begin
         dl_v <= LATENCY'({dl_v, enable});
      end
   end

   // Delay-line operand payload; qualified by dl_v so it needs no reset.
   always_ff @(posedge clk) begin
      dl_a <= DL_W'({dl_a, a});
      dl_b <= DL_W'({dl_b, b});
   end

   // FIFO storage; the popped slot may be rewritten in the same cycle.
   always_ff @(posedge clk) begin
      if (push_ok_c && !clear) begin
         mem[wr_ptr] <= new_rec_c;
      end
   end

   // Push/pop decisions, pointer and occupancy updates.
   always_comb begin
      hs_c         = out_valid && out_ready;
      pop_c        = hs_c && (w == 2'd3);
      push_c       = dl_v[LATENCY-1];
      push_ok_c    = push_c && ((count < CNT_W'(DEPTH)) || pop_c);
      new_rec_c    = '{a: dl_a[LATENCY-1], b: dl_b[LATENCY-1], r: r, omu: omu};
      count_nxt    = count + CNT_W'(push_ok_c) - CNT_W'(pop_c);
      rd_ptr_nxt   = rd_ptr + ADDR_W'(pop_c);
      wr_ptr_nxt   = wr_ptr + ADDR_W'(push_ok_c);
      overflow_nxt = overflow | (push_c & ~push_ok_c);
   end

   // Serializer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         w     <= 2'd0;
      end else if (clear) begin
         state <= IDLE;
         w     <= 2'd0;
      end else begin
         state <= state_nxt;
         w     <= w_nxt;
      end
   end

   // Serializer next state and next output word, with head bypass on push.
   always_comb begin
      state_nxt     = state;
      w_nxt         = w;
      head_c        = mem[rd_ptr_nxt];
      out_valid_nxt = 1'b0;
      out_last_nxt  = 1'b0;
      out_data_nxt  = '0;
      case (state)
         IDLE: begin
            if (push_ok_c) begin
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (hs_c) begin
               w_nxt = w + 2'd1;
               if (pop_c && (count_nxt == '0)) begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (push_ok_c && (wr_ptr == rd_ptr_nxt)) begin
         head_c = new_rec_c;
      end
      out_valid_nxt = (state_nxt == SEND);
      out_last_nxt  = out_valid_nxt && (w_nxt == 2'd3);
      if (out_valid_nxt) begin
         out_data_nxt = word_sel(head_c, w_nxt);
      end
   end

   // FIFO bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         count     <= count_nxt;
         overflow  <= overflow_nxt;
         out_data  <= out_data_nxt;
         out_valid <= out_valid_nxt;
         out_last  <= out_last_nxt;
      end
   end

endmodule

// File: tb/tb_fpmul_capture.sv
// Bench for fpmul_capture: directed records on a LATENCY=1 and a LATENCY=3
// instance; expected words are queued at stimulus time and compared by
// independent monitors whenever a word is handed off.

module tb_fpmul_capture;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        out_ready = 1'b0;

   logic        en1 = 1'b0, omu1 = 1'b0;
   logic [31:0] a1 = '0, b1 = '0, r1 = '0;
   logic [31:0] d1;
   logic        v1, l1, ov1;
   logic [3:0]  cnt1;

   logic        en3 = 1'b0, omu3 = 1'b0;
   logic [31:0] a3 = '0, b3 = '0, r3 = '0;
   logic [31:0] d3;
   logic        v3, l3, ov3;
   logic [3:0]  cnt3;

   int          n_chk = 0;
   int          n_fail = 0;
   int          acc1 = 0;
   int          acc3 = 0;
   logic [32:0] q1[$];
   logic [32:0] q3[$];
   logic [32:0] e1, e3;
   logic        pv1 = 1'b0, pr1 = 1'b0, pl1 = 1'b0;
   logic [31:0] pd1 = '0;
   logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   always #5 clk = ~clk;

   fpmul_capture #(.LATENCY(1), .DEPTH(8), .ADDR_W(3)) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .enable(en1),
      .a(a1), .b(b1), .r(r1), .omu(omu1),
      .out_data(d1), .out_valid(v1), .out_last(l1), .out_ready(out_ready),
      .overflow(ov1), .count(cnt1)
   );

   fpmul_capture #(.LATENCY(3), .DEPTH(8), .ADDR_W(3)) u3 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .enable(en3),
      .a(a3), .b(b3), .r(r3), .omu(omu3),
      .out_data(d3), .out_valid(v3), .out_last(l3), .out_ready(out_ready),
      .overflow(ov3), .count(cnt3)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   task automatic push_exp(input int which, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [31:0] er, input logic eo);
      logic [32:0] wd [4];
      wd[0] = {1'b0, ea};
      wd[1] = {1'b0, eb};
      wd[2] = {1'b0, er};
      wd[3] = {1'b1, 31'b0, eo};
      for (int k = 0; k < 4; k++) begin
         if (which == 1) q1.push_back(wd[k]);
         else            q3.push_back(wd[k]);
      end
   endtask

   task automatic wait_idle(input int which, input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         step;
         #2;
         if (which == 1) done = !v1 && (cnt1 == 4'd0) && (q1.size() == 0);
         else            done = !v3 && (cnt3 == 4'd0) && (q3.size() == 0);
      end
      check1("drain_done", done, 1'b1);
   endtask

   // Monitor for the LATENCY=1 instance: stall stability and word order.
   always begin
      @(negedge clk);
      #1;
      if (rst_n && pv1 && !pr1 && v1) begin
         check32("stall_data1", d1, pd1);
         check1("stall_last1", l1, pl1);
      end
      if (rst_n && v1 && out_ready) begin
         acc1++;
         if (q1.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word1: got %h expected no word", d1);
         end else begin
            e1 = q1.pop_front();
            check32("word_data1", d1, e1[31:0]);
            check1("word_last1", l1, e1[32]);
         end
      end
      pv1 = v1 && rst_n;
      pr1 = out_ready;
      pd1 = d1;
      pl1 = l1;
   end

   // Monitor for the LATENCY=3 instance.
   always begin
      @(negedge clk);
      #1;
      if (rst_n && v3 && out_ready) begin
         acc3++;
         if (q3.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word3: got %h expected no word", d3);
         end else begin
            e3 = q3.pop_front();
            check32("word_data3", d3, e3[31:0]);
            check1("word_last3", l3, e3[32]);
         end
      end
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      int base;
      logic [31:0] opa [3] = '{32'h3f800000, 32'h7f000000, 32'h40400000};
      logic [31:0] opb [3] = '{32'h40000000, 32'h7f000000, 32'h40400000};
      logic [31:0] res [3] = '{32'h40000000, 32'h7f800000, 32'h41100000};
      logic        flg [3] = '{1'b0, 1'b1, 1'b0};

      // Reset values
      repeat (3) step;
      #1;
      check1("rst_valid", v1, 1'b0);
      check1("rst_last", l1, 1'b0);
      check32("rst_data", d1, 32'h0);
      check1("rst_overflow", ov1, 1'b0);
      check32("rst_count", 32'(cnt1), 32'd0);
      step;
      rst_n = 1'b1;

      // Single record, ready always high
      step;
      out_ready = 1'b1;
      en1 = 1'b1; a1 = 32'h3f800000; b1 = 32'h40000000;
      push_exp(1, 32'h3f800000, 32'h40000000, 32'h40000000, 1'b0);
      step;
      en1 = 1'b0; r1 = 32'h40000000; omu1 = 1'b0;
      step;
      #1;
      check1("first_valid", v1, 1'b1);
      check32("first_word", d1, 32'h3f800000);
      wait_idle(1, 20);
      check32("single_count", 32'(cnt1), 32'd0);

      // Backpressure with ready pattern 1,0,0,1
      step;
      base = acc1;
      en1 = 1'b1; a1 = 32'h40a00000; b1 = 32'hc0400000;
      push_exp(1, 32'h40a00000, 32'hc0400000, 32'hc1700000, 1'b0);
      step;
      en1 = 1'b0; r1 = 32'hc1700000;
      for (int i = 0; i < 24; i++) begin
         step;
         out_ready = pat[i % 4];
      end
      step;
      out_ready = 1'b1;
      step;
      #2;
      check32("bp_accepted", 32'(acc1 - base), 32'd4);
      check32("bp_queue_empty", 32'(q1.size()), 32'd0);

      // Overflow: 10 records into a depth-8 FIFO with ready low
      step;
      out_ready = 1'b0;
      base = acc1;
      for (int i = 0; i < 10; i++) begin
         step;
         en1 = 1'b1; a1 = 32'(i); b1 = 32'(i + 1);
         if (i > 0) r1 = 32'((i - 1) * 16);
         if (i < 8) push_exp(1, 32'(i), 32'(i + 1), 32'(i * 16), 1'b0);
      end
      step;
      en1 = 1'b0; r1 = 32'(9 * 16);
      step;
      step;
      #1;
      check32("ovf_count", 32'(cnt1), 32'd8);
      check1("ovf_flag", ov1, 1'b1);
      step;
      out_ready = 1'b1;
      wait_idle(1, 60);
      check32("ovf_words", 32'(acc1 - base), 32'd32);
      check1("ovf_sticky", ov1, 1'b1);
      step;
      clear = 1'b1;
      step;
      clear = 1'b0;
      #1;
      check1("ovf_cleared", ov1, 1'b0);

      // Full FIFO with pop coinciding with a new push
      step;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step;
         en1 = 1'b1; a1 = 32'(100 + i); b1 = 32'(200 + i);
         if (i > 0) r1 = 32'(300 + i - 1);
         push_exp(1, 32'(100 + i), 32'(200 + i), 32'(300 + i), 1'b0);
      end
      step;
      en1 = 1'b0; r1 = 32'(307);
      step;
      step;
      #1;
      check32("full_count", 32'(cnt1), 32'd8);
      step;
      out_ready = 1'b1;
      step;
      step;
      en1 = 1'b1; a1 = 32'h0000abcd; b1 = 32'h00001234;
      push_exp(1, 32'h0000abcd, 32'h00001234, 32'h00005678, 1'b1);
      step;
      en1 = 1'b0; r1 = 32'h00005678; omu1 = 1'b1;
      step;
      #1;
      check32("full_pop_count", 32'(cnt1), 32'd8);
      check1("full_pop_no_ovf", ov1, 1'b0);
      step;
      omu1 = 1'b0;
      wait_idle(1, 80);

      // LATENCY=3 alignment, enable every other cycle
      for (int t = 0; t < 12; t++) begin
         step;
         en3 = ((t % 2) == 0) && (t < 6);
         if (en3) begin
            a3 = opa[t / 2]; b3 = opb[t / 2];
            push_exp(3, opa[t / 2], opb[t / 2], res[t / 2], flg[t / 2]);
         end
         if ((t >= 3) && (((t - 3) % 2) == 0) && (((t - 3) / 2) < 3)) begin
            r3 = res[(t - 3) / 2]; omu3 = flg[(t - 3) / 2];
         end else begin
            r3 = 32'hdeadbeef; omu3 = 1'b1;
         end
      end
      step;
      en3 = 1'b0; omu3 = 1'b0;
      wait_idle(3, 40);
      check32("lat3_words", 32'(acc3), 32'd12);

      // clear while word1 of a record is presented
      step;
      en1 = 1'b1; a1 = 32'h11111111; b1 = 32'h22222222;
      push_exp(1, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0);
      step;
      en1 = 1'b0; r1 = 32'h33333333;
      step;
      step;
      clear = 1'b1;
      out_ready = 1'b0;
      q1.delete();
      #1;
      check32("clear_at_word1", d1, 32'h22222222);
      step;
      clear = 1'b0;
      #1;
      check1("clear_valid", v1, 1'b0);
      check1("clear_last", l1, 1'b0);
      check32("clear_count", 32'(cnt1), 32'd0);
      check1("clear_overflow", ov1, 1'b0);

      // Asynchronous reset mid-stream
      step;
      out_ready = 1'b1;
      en1 = 1'b1; a1 = 32'h44444444; b1 = 32'h55555555;
      push_exp(1, 32'h44444444, 32'h55555555, 32'h66666666, 1'b1);
      step;
      en1 = 1'b0; r1 = 32'h66666666; omu1 = 1'b1;
      step;
      step;
      #3;
      rst_n = 1'b0;
      q1.delete();
      #1;
      check1("arst_valid", v1, 1'b0);
      check1("arst_last", l1, 1'b0);
      check32("arst_data", d1, 32'h0);
      check32("arst_count", 32'(cnt1), 32'd0);
      step;
      rst_n = 1'b1;
      omu1 = 1'b0;

      // Recovery after reset
      step;
      en1 = 1'b1; a1 = 32'h3f800000; b1 = 32'h3f800000;
      push_exp(1, 32'h3f800000, 32'h3f800000, 32'h3f800000, 1'b0);
      step;
      en1 = 1'b0; r1 = 32'h3f800000;
      wait_idle(1, 20);

      check32("q1_left", 32'(q1.size()), 32'd0);
      check32("q3_left", 32'(q3.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
